// File: rtl/regfile_writeback_arbiter.sv
// Buffers ALU/SFU/LSU results per source and round-robins them onto the single RF write port.
// Latency: accepted at edge E, write/clear strobes visible after edge E+1; 1 commit/cycle sustained.
// Backpressure: src_ready[i] = !full[i], taken from the buffer occupancy only, never from src_valid.
module regfile_writeback_arbiter #(
  parameter int NUM_SOURCES      = 3,
  parameter int THREADS_PER_WARP = 32,
  parameter int FIFO_DEPTH       = 2
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [NUM_SOURCES-1:0]                           src_valid,
  output logic [NUM_SOURCES-1:0]                           src_ready,
  input  logic [NUM_SOURCES-1:0][5:0]                      src_warp_id,
  input  logic [NUM_SOURCES-1:0][4:0]                      src_reg,
  input  logic [31:0]                                      src_data [NUM_SOURCES-1:0][THREADS_PER_WARP-1:0],
  input  logic [NUM_SOURCES-1:0][THREADS_PER_WARP-1:0]     src_mask,
  output logic [4:0]                                       rd_addr,
  output logic [5:0]                                       rd_warp_id,
  output logic [31:0]                                      rd_data [THREADS_PER_WARP-1:0],
  output logic [THREADS_PER_WARP-1:0]                      rd_thread_mask,
  output logic                                             rd_write_en,
  output logic [4:0]                                       clear_busy_reg,
  output logic [5:0]                                       clear_busy_warp,
  output logic                                             clear_busy_en,
  output logic [31:0]                                      writes_committed,
  output logic [31:0]                                      stall_cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

  typedef struct packed {
    logic [5:0]                         warp;
    logic [4:0]                         rg;
    logic [THREADS_PER_WARP-1:0][31:0]  data;
    logic [THREADS_PER_WARP-1:0]        mask;
  } wb_entry_t;

  wb_entry_t              head [NUM_SOURCES];
  wb_entry_t              grant_ent;
  logic [NUM_SOURCES-1:0] fifo_empty;
  logic [NUM_SOURCES-1:0] fifo_full;
  logic [NUM_SOURCES-1:0] pop;
  logic [SW-1:0]          rr_ptr;
  logic [SW-1:0]          grant_idx;
  logic                   grant_vld;

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_src
    wb_entry_t      mem [FIFO_DEPTH];
    wb_entry_t      push_ent;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;

    always_comb begin
      push_ent.warp = src_warp_id[i];
      push_ent.rg   = src_reg[i];
      push_ent.mask = src_mask[i];
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
        push_ent.data[t] = src_data[i][t];
      end
    end

    assign fifo_full[i]  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty[i] = (count == '0);
    assign src_ready[i]  = ~fifo_full[i];
    assign push          = src_valid[i] & src_ready[i];
    assign head[i]       = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
      end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_SOURCES) s = s - NUM_SOURCES;
    return SW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest non-empty source at/after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
      if (!fifo_empty[rr_index(rr_ptr, k)]) begin
        grant_vld = 1'b1;
        grant_idx = rr_index(rr_ptr, k);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_vld) pop[grant_idx] = 1'b1;
  end

  assign grant_ent = head[grant_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr           <= '0;
      rd_addr          <= '0;
      rd_warp_id       <= '0;
      rd_thread_mask   <= '0;
      rd_write_en      <= 1'b0;
      clear_busy_reg   <= '0;
      clear_busy_warp  <= '0;
      clear_busy_en    <= 1'b0;
      writes_committed <= '0;
      stall_cycles     <= '0;
      for (int t = 0; t < THREADS_PER_WARP; t++) begin
        rd_data[t] <= '0;
      end
    end else begin
      rd_write_en   <= 1'b0;
      clear_busy_en <= 1'b0;
      if (grant_vld) begin
        rr_ptr           <= (grant_idx == SW'(NUM_SOURCES - 1)) ? '0 : grant_idx + 1'b1;
        rd_addr          <= grant_ent.rg;
        rd_warp_id       <= grant_ent.warp;
        rd_thread_mask   <= grant_ent.mask;
        clear_busy_reg   <= grant_ent.rg;
        clear_busy_warp  <= grant_ent.warp;
        clear_busy_en    <= 1'b1;
        // r0 is hardwired and an empty mask writes nothing, but the busy bit must still clear.
        rd_write_en      <= (grant_ent.rg != 5'd0) && (|grant_ent.mask);
        writes_committed <= writes_committed + 32'd1;
        for (int t = 0; t < THREADS_PER_WARP; t++) begin
          rd_data[t] <= grant_ent.data[t];
        end
      end
      if (|(src_valid & ~src_ready)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomised bench for regfile_writeback_arbiter against a queue-based behavioural model.
module tb_regfile_writeback_arbiter;
  localparam int N = 3;
  localparam int T = 32;
  localparam int D = 2;

  typedef struct packed {
    logic [5:0]          warp;
    logic [4:0]          rg;
    logic [T-1:0][31:0]  data;
    logic [T-1:0]        mask;
  } ent_t;

  logic                clk;
  logic                rst_n;
  logic [N-1:0]        src_valid;
  logic [N-1:0]        src_ready;
  logic [N-1:0][5:0]   src_warp_id;
  logic [N-1:0][4:0]   src_reg;
  logic [31:0]         src_data [N-1:0][T-1:0];
  logic [N-1:0][T-1:0] src_mask;
  logic [4:0]          rd_addr;
  logic [5:0]          rd_warp_id;
  logic [31:0]         rd_data [T-1:0];
  logic [T-1:0]        rd_thread_mask;
  logic                rd_write_en;
  logic [4:0]          clear_busy_reg;
  logic [5:0]          clear_busy_warp;
  logic                clear_busy_en;
  logic [31:0]         writes_committed;
  logic [31:0]         stall_cycles;

  regfile_writeback_arbiter #(.NUM_SOURCES(N), .THREADS_PER_WARP(T), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_warp_id(src_warp_id),
    .src_reg(src_reg), .src_data(src_data), .src_mask(src_mask),
    .rd_addr(rd_addr), .rd_warp_id(rd_warp_id), .rd_data(rd_data),
    .rd_thread_mask(rd_thread_mask), .rd_write_en(rd_write_en),
    .clear_busy_reg(clear_busy_reg), .clear_busy_warp(clear_busy_warp),
    .clear_busy_en(clear_busy_en), .writes_committed(writes_committed),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  int          checks = 0;
  int          errors = 0;
  ent_t        mq [N][$];
  ent_t        cur [N];
  logic [N-1:0] acc;
  ent_t        e_out;
  bit          e_en, e_we;
  logic [31:0] e_wc, e_stall;
  int          rr;
  int          grant_seq [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    e_out = '0; e_en = 0; e_we = 0; e_wc = '0; e_stall = '0; rr = 0; acc = '0;
  endtask

  task automatic set_src(input int i, input ent_t e);
    cur[i] = e;
    src_warp_id[i] = e.warp;
    src_reg[i]     = e.rg;
    src_mask[i]    = e.mask;
    for (int t = 0; t < T; t++) src_data[i][t] = e.data[t];
  endtask

  function automatic ent_t rand_ent();
    ent_t e;
    int   m;
    e.warp = 6'($urandom_range(0, 63));
    e.rg   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    m = $urandom_range(0, 7);
    e.mask = (m == 0) ? '0 : (m < 4) ? '1 : T'($urandom);
    for (int t = 0; t < T; t++) e.data[t] = $urandom;
    return e;
  endfunction

  task automatic compare_outputs();
    int bl;
    bl = -1;
    for (int t = 0; t < T; t++) if (bl < 0 && rd_data[t] !== e_out.data[t]) bl = t;
    if (bl < 0) bl = 0;
    chk("clear_busy_en", clear_busy_en, e_en);
    chk("rd_write_en", rd_write_en, e_we);
    chk("rd_addr", rd_addr, e_out.rg);
    chk("rd_warp_id", rd_warp_id, e_out.warp);
    chk("clear_busy_reg", clear_busy_reg, e_out.rg);
    chk("clear_busy_warp", clear_busy_warp, e_out.warp);
    chk("rd_thread_mask", rd_thread_mask, e_out.mask);
    chk("rd_data", rd_data[bl], e_out.data[bl]);
    chk("writes_committed", writes_committed, e_wc);
    chk("stall_cycles", stall_cycles, e_stall);
  endtask

  // One cycle: called at negedge with inputs set; predicts the coming edge, then checks after it.
  task automatic step();
    logic [N-1:0] rdy;
    int           gi;
    bit           g;
    #1;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
    chk("src_ready", src_ready, rdy);
    if (|(src_valid & ~rdy)) e_stall = e_stall + 1;
    g = 0; gi = 0;
    for (int k = 0; k < N; k++) begin
      if (!g && mq[(rr + k) % N].size() > 0) begin
        g = 1; gi = (rr + k) % N;
      end
    end
    if (g) begin
      e_out = mq[gi].pop_front();
      e_en  = 1;
      e_we  = (e_out.rg != 0) && (e_out.mask != 0);
      rr    = (gi + 1) % N;
      e_wc  = e_wc + 1;
    end else begin
      e_en = 0; e_we = 0;
    end
    for (int i = 0; i < N; i++) begin
      acc[i] = src_valid[i] && rdy[i];
      if (acc[i]) mq[i].push_back(cur[i]);
    end
    @(posedge clk);
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic drive_random(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!src_valid[i] || acc[i]) begin
        src_valid[i] = ($urandom_range(0, 99) < pct);
        if (src_valid[i]) set_src(i, rand_ent());
      end
    end
  endtask

  initial begin
    ent_t e;
    int   seq;
    rst_n = 1'b0;
    src_valid = '0;
    for (int i = 0; i < N; i++) set_src(i, '0);
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset clear_busy_en", clear_busy_en, 1'b0);
    chk("reset rd_write_en", rd_write_en, 1'b0);
    chk("reset writes_committed", writes_committed, 32'd0);
    chk("reset rd_data0", rd_data[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset src_ready", src_ready, 3'b111);
    @(negedge clk);

    // All sources valid for 12 cycles from rr=0; warp tags carry the source index.
    seq = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] || acc[i]) begin
          e = rand_ent();
          e.warp = {2'(i), 4'(seq)};
          seq++;
          src_valid[i] = 1'b1;
          set_src(i, e);
        end
      end
      step();
      if (clear_busy_en) grant_seq.push_back(int'(clear_busy_warp[5:4]));
    end
    src_valid = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (clear_busy_en) grant_seq.push_back(int'(clear_busy_warp[5:4]));
    end
    chk("grant_seq length", grant_seq.size() >= 6, 1'b1);
    for (int k = 0; k < 6 && k < grant_seq.size(); k++) chk("grant order", grant_seq[k], k % 3);
    chk("stall rose", stall_cycles != 0, 1'b1);

    // Single ALU result: warp 3, reg 7, lane t = t+100.
    e = '0; e.warp = 6'd3; e.rg = 5'd7; e.mask = '1;
    for (int t = 0; t < T; t++) e.data[t] = 32'(t + 100);
    set_src(0, e); src_valid = 3'b001;
    seq = int'(writes_committed);
    step();
    src_valid = '0;
    step();
    chk("alu rd_write_en", rd_write_en, 1'b1);
    chk("alu clear_busy_en", clear_busy_en, 1'b1);
    chk("alu rd_warp_id", rd_warp_id, 6'd3);
    chk("alu rd_addr", rd_addr, 5'd7);
    chk("alu rd_data[5]", rd_data[5], 32'd105);
    chk("alu writes_committed", writes_committed - 32'(seq), 32'd1);
    step();

    // Register 0 with mask 0xF, then register 9 with empty mask: clear only.
    e = rand_ent(); e.rg = 5'd0; e.mask = 32'hF;
    set_src(1, e); src_valid = 3'b010;
    step(); src_valid = '0; step();
    chk("r0 rd_write_en", rd_write_en, 1'b0);
    chk("r0 clear_busy_en", clear_busy_en, 1'b1);
    chk("r0 clear_busy_reg", clear_busy_reg, 5'd0);
    e = rand_ent(); e.rg = 5'd9; e.mask = '0;
    set_src(1, e); src_valid = 3'b010;
    step(); src_valid = '0; step();
    chk("mask0 rd_write_en", rd_write_en, 1'b0);
    chk("mask0 clear_busy_en", clear_busy_en, 1'b1);
    chk("mask0 clear_busy_reg", clear_busy_reg, 5'd9);

    // LSU A then B to warp 1 reg 4, back to back.
    e = '0; e.warp = 6'd1; e.rg = 5'd4; e.mask = '1;
    for (int t = 0; t < T; t++) e.data[t] = 32'hA000_0000 + 32'(t);
    set_src(2, e); src_valid = 3'b100;
    step();
    for (int t = 0; t < T; t++) e.data[t] = 32'hB000_0000 + 32'(t);
    set_src(2, e);
    step();
    chk("lsu A first", rd_data[0], 32'hA000_0000);
    src_valid = '0;
    step();
    chk("lsu B last", rd_data[1], 32'hB000_0001);
    step();

    // Random traffic with varying load.
    for (int blk = 0; blk < 15; blk++) begin
      int pct;
      pct = $urandom_range(20, 100);
      for (int c = 0; c < 100; c++) begin
        drive_random(pct);
        step();
      end
    end

    // Fill the buffers, then reset mid-operation.
    src_valid = '0;
    for (int c = 0; c < 4; c++) begin
      drive_random(100);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk("midreset clear_busy_en", clear_busy_en, 1'b0);
    chk("midreset rd_write_en", rd_write_en, 1'b0);
    chk("midreset writes_committed", writes_committed, 32'd0);
    chk("midreset stall_cycles", stall_cycles, 32'd0);
    src_valid = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after reset src_ready", src_ready, 3'b111);
    for (int c = 0; c < 5; c++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
